or1200_vlx_packer: RTL

- Parametrised successor to the OR1200 VLX bit-writer datapath and store unit.
- Accepts variable-length codes of up to MAX_BITS bits per put, packs them MSB-first into an ACC_W-bit accumulator, and emits bytes to memory through a byte-store handshake.
- Optional JPEG 0xFF->0xFF,0x00 byte stuffing; flush pads the partial byte with 1s.
- Stalls the CPU whenever a put cannot be accepted or a flush is in progress.

---
 rtl/or1200_vlx_packer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/or1200_vlx_packer.sv
// Variable-length code packer: MSB-first accumulator draining bytes to memory,
// with optional JPEG 0xFF stuffing and a pad-with-ones flush.
module or1200_vlx_packer #(
    parameter int MAX_BITS = 32,
    parameter int ACC_W    = 64,
    parameter int STUFF_EN = 1,
    parameter int ADDR_W   = 32,
    localparam int LW = $clog2(MAX_BITS + 1),
    localparam int FW = $clog2(ACC_W + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              put_valid_i,
    input  logic [MAX_BITS-1:0] put_bits_i,
    input  logic [LW-1:0]     put_len_i,
    input  logic              flush_i,
    input  logic              set_addr_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              ack_i,
    output logic              put_ready_o,
    output logic              stall_cpu_o,
    output logic              store_byte_o,
    output logic [ADDR_W-1:0] vlx_addr_o,
    output logic [7:0]        dat_o,
    output logic [FW-1:0]     fill_o,
    output logic              flush_done_o
);

    typedef enum logic [2:0] {IDLE, STORE, STUFF, FLUSH_PAD, FLUSH_DRAIN} state_t;

    localparam logic [FW-1:0] RDY_MAX = FW'(ACC_W - MAX_BITS);
    localparam logic [FW-1:0] F8      = FW'(8);
    localparam logic [FW-1:0] F16     = FW'(16);
    localparam logic [FW-1:0] FACC    = FW'(ACC_W);

    state_t            state, state_n;
    logic [ACC_W-1:0]  acc, acc_n, code;
    logic [FW-1:0]     fill, fill_n;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0]        dat_n;
    logic              done_n, flush_req, req_n, draining, drain_n;
    logic              put_acc, flush_new, shift;
    logic [2:0]        pad;

    // Valid bits sit left-aligned at the top of acc; the top byte goes out first.
    assign put_ready_o  = (fill <= RDY_MAX) && !draining;
    assign stall_cpu_o  = (put_valid_i && !put_ready_o) || draining;
    assign store_byte_o = (state == STORE) || (state == STUFF);
    assign fill_o       = fill;
    assign put_acc      = put_valid_i && put_ready_o && (put_len_i != '0);
    assign flush_new    = flush_i && !draining && !flush_req;
    assign pad          = 3'd0 - fill[2:0];
    assign code         = ACC_W'(put_bits_i)
                        & ((ACC_W'(1) << put_len_i) - ACC_W'(1));

    always_comb begin
        state_n = state;
        acc_n   = acc;
        fill_n  = fill;
        addr_n  = vlx_addr_o;
        dat_n   = dat_o;
        done_n  = 1'b0;
        req_n   = flush_req;
        drain_n = draining;
        shift   = 1'b0;
        unique case (state)
            IDLE: begin
                if (set_addr_i && fill == '0)
                    addr_n = addr_i;
                if (flush_new || flush_req) begin
                    req_n = 1'b0;
                    if (fill == '0 && !put_acc) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = FLUSH_PAD;
                        drain_n = 1'b1;
                    end
                end else if (fill >= F8) begin
                    dat_n   = acc[ACC_W-1 -: 8];
                    state_n = STORE;
                end
            end
            STORE: begin
                if (flush_new)
                    req_n = 1'b1;
                if (ack_i) begin
                    shift  = 1'b1;
                    addr_n = vlx_addr_o + 1'b1;
                    if (STUFF_EN != 0 && dat_o == 8'hFF) begin
                        dat_n   = 8'h00;
                        state_n = STUFF;
                    end else if (fill >= F16) begin
                        dat_n = acc[ACC_W-9 -: 8];
                    end else begin
                        state_n = draining ? FLUSH_DRAIN : IDLE;
                    end
                end
            end
            STUFF: begin
                if (flush_new)
                    req_n = 1'b1;
                // The stuffed byte's source was already shifted out on its own ack.
                if (ack_i) begin
                    addr_n = vlx_addr_o + 1'b1;
                    if (fill >= F8) begin
                        dat_n   = acc[ACC_W-1 -: 8];
                        state_n = STORE;
                    end else begin
                        state_n = draining ? FLUSH_DRAIN : IDLE;
                    end
                end
            end
            FLUSH_PAD: begin
                acc_n   = acc | (((ACC_W'(1) << pad) - ACC_W'(1))
                                 << (FACC - fill - FW'(pad)));
                fill_n  = fill + FW'(pad);
                state_n = FLUSH_DRAIN;
            end
            FLUSH_DRAIN: begin
                if (fill == '0) begin
                    done_n  = 1'b1;
                    drain_n = 1'b0;
                    state_n = IDLE;
                end else begin
                    dat_n   = acc[ACC_W-1 -: 8];
                    state_n = STORE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (shift) begin
            acc_n  = acc_n << 8;
            fill_n = fill_n - F8;
        end
        if (put_acc) begin
            acc_n  = acc_n | (code << (FACC - fill_n - FW'(put_len_i)));
            fill_n = fill_n + FW'(put_len_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            acc          <= '0;
            fill         <= '0;
            vlx_addr_o   <= '0;
            dat_o        <= '0;
            flush_done_o <= 1'b0;
            flush_req    <= 1'b0;
            draining     <= 1'b0;
        end else begin
            state        <= state_n;
            acc          <= acc_n;
            fill         <= fill_n;
            vlx_addr_o   <= addr_n;
            dat_o        <= dat_n;
            flush_done_o <= done_n;
            flush_req    <= req_n;
            draining     <= drain_n;
        end
    end

endmodule
